// File: rtl/uart_pkg.sv
// uart_pkg: shared UART definitions for the TX/RX paths
// Contents: FSM state encoding, parity-type constants, idle line level.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;
    localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: holds the accepted byte and walks a bit index across it
// Ports:
//   CLK, RST          baud clock, asynchronous active-low reset
//   load              capture p_data and clear the index (frame acceptance)
//   clear             clear the index (entry to the data bits)
//   step              advance to the next data bit
//   p_data            parallel byte from upstream
//   data_q            latched byte (used for parity)
//   ser_bit           data bit selected by the index of the next cycle
//   ser_done          index is at the last data bit
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  load,
    input  logic                  clear,
    input  logic                  step,
    input  logic [Data_width-1:0] p_data,
    output logic [Data_width-1:0] data_q,
    output logic                  ser_bit,
    output logic                  ser_done
);

    localparam int CW = Data_width > 1 ? $clog2(Data_width) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb cnt_d = (load || clear) ? '0 : step ? cnt_q + CW'(1) : cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (load)
                data_q <= p_data;
            cnt_q <= cnt_d;
        end
    end

    // Look ahead by one index so the output register in the top can
    // capture the bit that belongs to the next cycle.
    assign ser_bit  = data_q[cnt_d];
    assign ser_done = cnt_q == CW'(Data_width - 1);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, one serial bit per baud clock
// Ports:
//   CLK          TX baud clock, one bit per rising edge
//   RST          asynchronous active-low reset
//   P_DATA       parallel data, sampled on acceptance only
//   Data_Valid   send request (pulse or level), ignored while busy
//   PAR_EN       insert parity bit after the data bits
//   PAR_TYP      0 = even, 1 = odd parity
//   TX_OUT       registered serial line, idles high
//   Busy         registered, high while a frame is in flight
// Build option: define UART_TX_STOP2_EN for two stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int Data_width = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [Data_width-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic                  TX_OUT,
    output logic                  Busy
);

    uart_state_e           state_q;
    uart_state_e           state_d;
    logic                  par_en_q;
    logic                  par_typ_q;
    logic                  load;
    logic                  clear;
    logic                  step;
    logic [Data_width-1:0] data_q;
    logic                  ser_bit;
    logic                  ser_done;
    logic                  par_bit;
    logic                  tx_d;
`ifdef UART_TX_STOP2_EN
    logic                  stop2_q;
`endif

    uart_tx_serializer #(
        .Data_width(Data_width)
    ) u_ser (
        .CLK     (CLK),
        .RST     (RST),
        .load    (load),
        .clear   (clear),
        .step    (step),
        .p_data  (P_DATA),
        .data_q  (data_q),
        .ser_bit (ser_bit),
        .ser_done(ser_done)
    );

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clear   = 1'b0;
        step    = 1'b0;
        case (state_q)
            IDLE: begin
                load    = Data_Valid;
                state_d = Data_Valid ? START : IDLE;
            end
            START: begin
                clear   = 1'b1;
                state_d = DATA;
            end
            DATA: begin
                step    = !ser_done;
                state_d = !ser_done ? DATA : par_en_q ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
`ifdef UART_TX_STOP2_EN
            STOP: state_d = stop2_q ? IDLE : STOP;
`else
            STOP: state_d = IDLE;
`endif
            default: state_d = IDLE;
        endcase
    end

    assign par_bit = ^data_q ^ (par_typ_q == PAR_ODD);

    // Outputs are registered from the next state so they line up with the
    // state register and no input reaches TX_OUT/Busy combinationally.
    assign tx_d = (state_d == START)  ? 1'b0    :
                  (state_d == DATA)   ? ser_bit :
                  (state_d == PARITY) ? par_bit : LINE_IDLE;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            TX_OUT    <= LINE_IDLE;
            Busy      <= 1'b0;
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
        end else begin
            state_q <= state_d;
            TX_OUT  <= tx_d;
            Busy    <= state_d != IDLE;
            if (load) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
        end
    end

`ifdef UART_TX_STOP2_EN
    // Marks the second stop cycle; set after the first STOP cycle only.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            stop2_q <= 1'b0;
        else
            stop2_q <= (state_q == STOP) && !stop2_q;
    end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: self-checking bench for uart_tx against a frame-queue model
module tb_uart_tx;

    logic       CLK        = 1'b0;
    logic       RST        = 1'b0;
    logic [7:0] P_DATA     = 8'h00;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN     = 1'b0;
    logic       PAR_TYP    = 1'b0;
    logic       TX_OUT;
    logic       Busy;

    int   vectors     = 0;
    int   miscompares = 0;
    logic exp_q[$];

    uart_tx #(
        .Data_width(8)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .P_DATA    (P_DATA),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .TX_OUT    (TX_OUT),
        .Busy      (Busy)
    );

    always #5 CLK = ~CLK;

    function automatic int frame_len(input logic en);
`ifdef UART_TX_STOP2_EN
        return 11 + int'(en);
`else
        return 10 + int'(en);
`endif
    endfunction

    // Line sequence of one frame, one entry per baud cycle.
    function automatic void push_frame(input logic [7:0] d, input logic en, input logic typ);
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++)
            exp_q.push_back(d[i]);
        if (en)
            exp_q.push_back(typ ? ~^d : ^d);
        exp_q.push_back(1'b1);
`ifdef UART_TX_STOP2_EN
        exp_q.push_back(1'b1);
`endif
    endfunction

    task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One baud cycle: drive inputs, advance the model at the edge, check at negedge.
    task automatic step(input logic dv, input logic [7:0] d, input logic en, input logic typ);
        Data_Valid = dv;
        P_DATA     = d;
        PAR_EN     = en;
        PAR_TYP    = typ;
        @(posedge CLK);
        if (!RST)
            exp_q.delete();
        else if (exp_q.size() != 0)
            void'(exp_q.pop_front());
        else if (dv)
            push_frame(d, en, typ);
        @(negedge CLK);
        check("tx", 12'(TX_OUT), 12'(exp_q.size() != 0 ? exp_q[0] : 1'b1));
        check("busy", 12'(Busy), 12'(exp_q.size() != 0));
    endtask

    task automatic noise();
        step(1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
    endtask

    // Sends one frame with scrambled inputs mid-frame; returns line bits and busy count.
    task automatic capture(input logic [7:0] d, input logic en, input logic typ,
                           output logic [11:0] bits, output int busy_n);
        bits   = '0;
        busy_n = 0;
        step(1'b1, d, en, typ);
        bits[0] = TX_OUT;
        busy_n += int'(Busy);
        for (int i = 1; i <= frame_len(en); i++) begin
            noise();
            if (i < 12)
                bits[i] = TX_OUT;
            busy_n += int'(Busy);
        end
    endtask

    logic [11:0] bits;
    int          busy_n;
    int          gap;

    initial begin
        repeat (3) step(1'b1, 8'hA5, 1'b1, 1'b0);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0);

        capture(8'hA5, 1'b1, 1'b0, bits, busy_n);
        check("a5_even_frame", {1'b0, bits[10:0]}, 12'h54A);
        check("a5_even_busy", 12'(busy_n), 12'(frame_len(1'b1)));

        capture(8'hA5, 1'b1, 1'b1, bits, busy_n);
        check("a5_odd_par", 12'(bits[9]), 12'd1);
        capture(8'hFF, 1'b1, 1'b1, bits, busy_n);
        check("ff_odd_par", 12'(bits[9]), 12'd1);
        capture(8'h07, 1'b1, 1'b0, bits, busy_n);
        check("07_even_par", 12'(bits[9]), 12'd1);

        capture(8'h00, 1'b0, 1'b0, bits, busy_n);
        check("00_nopar_frame", {2'b00, bits[9:0]}, 12'h200);
        check("00_nopar_busy", 12'(busy_n), 12'(frame_len(1'b0)));

        step(1'b1, 8'h99, 1'b1, 1'b0);
        for (int i = 1; i <= frame_len(1'b1); i++)
            step(i == 4 || i == frame_len(1'b1), 8'h3C, 1'b0, 1'b1);
        repeat (2) step(1'b0, 8'h3C, 1'b0, 1'b0);

        gap = 0;
        step(1'b1, 8'h55, 1'b0, 1'b0);
        for (int i = 1; i <= frame_len(1'b0); i++) begin
            step(1'b1, 8'h55, 1'b0, 1'b0);
            gap += int'(!Busy);
        end
        step(1'b1, 8'h0F, 1'b0, 1'b0);
        check("b2b_gap", 12'(gap), 12'd1);
        check("b2b_second_start", 12'({Busy, TX_OUT}), 12'b10);
        repeat (frame_len(1'b0) + 1) step(1'b0, 8'h0F, 1'b0, 1'b0);

        step(1'b1, 8'h00, 1'b1, 1'b0);
        repeat (3) noise();
        #2 RST = 1'b0;
        exp_q.delete();
        #1;
        check("async_rst_tx", 12'(TX_OUT), 12'd1);
        check("async_rst_busy", 12'(Busy), 12'd0);
        repeat (2) step(1'b1, 8'hFF, 1'b1, 1'b1);
        @(negedge CLK);
        RST = 1'b1;
        repeat (3) step(1'b0, 8'hFF, 1'b1, 1'b1);
        capture(8'hA5, 1'b1, 1'b0, bits, busy_n);
        check("post_rst_frame", {1'b0, bits[10:0]}, 12'h54A);

        repeat (400)
            step(1'($urandom_range(0, 3) == 0), 8'($urandom), 1'($urandom), 1'($urandom));
        repeat (frame_len(1'b1) + 1) noise();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
